// File: rtl/dlsc_axi_router_channel_sink.sv
// Per-sink stage of the AXI router channel fabric: ordered source queue, lane latch and lane-to-sink mux.
// Optional DLSC_AXI_ROUTER_SINK_REGSLICE_EN inserts a 2-entry skid buffer in front of the sink port.
module dlsc_axi_router_channel_sink #(
  parameter int DATA     = 32,
  parameter int MOT      = 16,
  parameter int SOURCES  = 1,
  parameter int SOURCESB = 1,
  parameter int LANES    = 1,
  parameter int LANESB   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  cmd_full,
  input  logic                  cmd_push,
  input  logic [SOURCESB-1:0]   cmd_source,
  output logic [SOURCES-1:0]    sink_source,
  input  logic                  arb_grant,
  input  logic [LANESB-1:0]     arb_grant_lane,
  output logic [LANES-1:0]      lane_out_ready,
  input  logic [LANES-1:0]      lane_out_valid,
  input  logic [LANES-1:0]      lane_out_last,
  input  logic [LANES*DATA-1:0] lane_out_data,
  input  logic                  sink_ready,
  output logic                  sink_valid,
  output logic                  sink_last,
  output logic [DATA-1:0]       sink_data
);

  logic                fifo_empty;
  logic [SOURCESB-1:0] head;
  logic                active;
  logic [LANESB-1:0]   lane;
  logic                done;
  logic                path_ready;
  logic                mux_valid;
  logic                mux_last;
  logic [DATA-1:0]     mux_data;
  logic                in_valid;

  generate
    if (SOURCES > 1) begin : g_fifo
      localparam int PTRB = (MOT > 1) ? $clog2(MOT) : 1;
      localparam int CNTB = $clog2(MOT + 1);

      logic [SOURCESB-1:0] mem [MOT];
      logic [PTRB-1:0]     wr_ptr;
      logic [PTRB-1:0]     rd_ptr;
      logic [CNTB-1:0]     count;
      logic                push_ok;
      logic                pop_ok;

      // a push into a completely full queue is dropped, even if a pop frees a slot
      assign push_ok = cmd_push && (count != CNTB'(MOT));
      assign pop_ok  = arb_grant && (count != '0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (push_ok) wr_ptr <= (wr_ptr == PTRB'(MOT-1)) ? '0 : wr_ptr + 1'b1;
          if (pop_ok)  rd_ptr <= (rd_ptr == PTRB'(MOT-1)) ? '0 : rd_ptr + 1'b1;
          if (push_ok && !pop_ok)      count <= count + 1'b1;
          else if (!push_ok && pop_ok) count <= count - 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= cmd_source;
      end

      assign head       = mem[rd_ptr];
      assign fifo_empty = (count == '0);
      assign cmd_full   = (count >= CNTB'(MOT-1));
    end else begin : g_nofifo
      logic unused_cmd;
      assign unused_cmd = ^{cmd_push, cmd_source};
      assign head       = '0;
      assign fifo_empty = 1'b0;
      assign cmd_full   = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      lane   <= '0;
    end else begin
      if (arb_grant) begin
        active <= 1'b1;
        lane   <= arb_grant_lane;
      end else if (done) begin
        active <= 1'b0;
      end
    end
  end

  always_comb begin
    sink_source = '0;
    if (!fifo_empty && (!active || done)) begin
      for (int s = 0; s < SOURCES; s++) begin
        if (head == SOURCESB'(s)) sink_source[s] = 1'b1;
      end
    end
  end

  always_comb begin
    mux_valid = 1'b0;
    mux_last  = 1'b0;
    mux_data  = '0;
    for (int n = 0; n < LANES; n++) begin
      if (lane == LANESB'(n)) begin
        mux_valid = lane_out_valid[n];
        mux_last  = lane_out_last[n];
        mux_data  = lane_out_data[n*DATA +: DATA];
      end
    end
  end

  assign in_valid = active && mux_valid;

  always_comb begin
    lane_out_ready = '0;
    for (int n = 0; n < LANES; n++) begin
      lane_out_ready[n] = active && (lane == LANESB'(n)) && path_ready;
    end
  end

`ifdef DLSC_AXI_ROUTER_SINK_REGSLICE_EN
  logic [DATA:0] sk_mem [2];
  logic          sk_wr;
  logic          sk_rd;
  logic [1:0]    sk_cnt;
  logic          sk_in;
  logic          sk_out;

  assign path_ready = (sk_cnt != 2'd2);
  assign sk_in      = in_valid && path_ready;
  assign sk_out     = sink_valid && sink_ready;
  // burst ends once its last beat is inside the buffer; the tail drains on its own
  assign done       = sk_in && mux_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk_wr  <= 1'b0;
      sk_rd  <= 1'b0;
      sk_cnt <= 2'd0;
    end else begin
      if (sk_in)  sk_wr <= ~sk_wr;
      if (sk_out) sk_rd <= ~sk_rd;
      if (sk_in && !sk_out)      sk_cnt <= sk_cnt + 2'd1;
      else if (!sk_in && sk_out) sk_cnt <= sk_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (sk_in) sk_mem[sk_wr] <= {mux_last, mux_data};
  end

  assign sink_valid = (sk_cnt != 2'd0);
  assign sink_last  = sk_mem[sk_rd][DATA];
  assign sink_data  = sk_mem[sk_rd][DATA-1:0];
`else
  assign path_ready = sink_ready;
  assign sink_valid = in_valid;
  assign sink_last  = mux_last;
  assign sink_data  = mux_data;
  assign done       = sink_valid && sink_ready && sink_last;
`endif

`ifndef SYNTHESIS
  a_grant_busy: assert property (@(posedge clk) disable iff (!rst_n) !(arb_grant && active && !done))
    else $error("arb_grant while a burst is still active");
  a_grant_empty: assert property (@(posedge clk) disable iff (!rst_n) !(arb_grant && fifo_empty))
    else $error("arb_grant with empty command queue");
`endif

endmodule
